// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light encodings and detector state shared by the loop detector
package traffic_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2,
        FAULT = 2'd3
    } det_state_t;

    function automatic logic is_green(input logic [2:0] light);
        return light == LIGHT_GREEN;
    endfunction

endpackage

// File: rtl/lr_loop_detector_if.sv
// rtl/lr_loop_detector_if.sv - loop sensor and controller-facing signals of the detector
interface lr_loop_detector_if #(
    parameter int QW = 4
);
    logic          loop_raw;
    logic [2:0]    lr_light;
    logic          lr_has_car;
    logic [QW-1:0] queue_len;
    logic          sensor_fault;

    modport master (
        input  loop_raw,
        input  lr_light,
        output lr_has_car,
        output queue_len,
        output sensor_fault
    );

    modport slave (
        output loop_raw,
        output lr_light,
        input  lr_has_car,
        input  queue_len,
        input  sensor_fault
    );
endinterface

// File: rtl/loop_debouncer.sv
// rtl/loop_debouncer.sv - two-flop synchronizer, debounce counter and rising-edge pulse
module loop_debouncer #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          s1;
    logic          s2;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            level_d <= level;
            // Any edge where the synchronized input agrees restarts the count.
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/lr_loop_detector.sv
// rtl/lr_loop_detector.sv - rural-road service request FSM with arrival queue and stuck-sensor fault
module lr_loop_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE  = 4,
    parameter int STUCK_MAX = 200,
    parameter int QW        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    lr_loop_detector_if.master bus
);
    localparam int SW = (STUCK_MAX < 2) ? 1 : $clog2(STUCK_MAX + 1);
    localparam logic [SW-1:0] STUCK_TOP = SW'(STUCK_MAX);
    localparam logic [SW-1:0] STUCK_PRE = SW'(STUCK_MAX - 1);
    localparam logic [QW-1:0] QUEUE_TOP = '1;

    logic          loop_db;
    logic          arr;
    logic          stuck_hit;
    logic [SW-1:0] stuck;
    logic [QW-1:0] queue;
    det_state_t    state;
    det_state_t    next;

    loop_debouncer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debouncer (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.loop_raw),
        .level (loop_db),
        .rise  (arr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stuck <= '0;
        end else if (!loop_db) begin
            stuck <= '0;
        end else if (stuck != STUCK_TOP) begin
            stuck <= stuck + 1'b1;
        end
    end

    assign stuck_hit = loop_db && (stuck == STUCK_PRE);

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (arr) next = REQ;
            REQ:     if (is_green(bus.lr_light)) next = SERVE;
            SERVE:   if (!is_green(bus.lr_light)) next = loop_db ? REQ : IDLE;
            FAULT:   if (!loop_db) next = IDLE;
            default: next = IDLE;
        endcase
        // A stuck sensor overrides whatever the light is doing.
        if (stuck_hit) next = FAULT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            queue <= '0;
        end else begin
            state <= next;
            if ((next == SERVE && state != SERVE) || ((next == FAULT) != (state == FAULT))) begin
                queue <= '0;
            end else if (state != FAULT && arr && queue != QUEUE_TOP) begin
                queue <= queue + 1'b1;
            end
        end
    end

    assign bus.lr_has_car   = (state == REQ) || (state == FAULT);
    assign bus.sensor_fault = (state == FAULT);
    assign bus.queue_len    = queue;

endmodule

// File: tb/tb_lr_loop_detector.sv
// tb/tb_lr_loop_detector.sv - directed self-checking bench for lr_loop_detector
module tb_lr_loop_detector;
    import traffic_pkg::*;

    localparam int QW = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    lr_loop_detector_if #(.QW(QW)) bus ();

    lr_loop_detector #(
        .DEBOUNCE  (4),
        .STUCK_MAX (200),
        .QW        (QW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            bus.loop_raw = 1'b1;
            tick(8);
            bus.loop_raw = 1'b0;
            tick(8);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.loop_raw = 1'b0;
        bus.lr_light = LIGHT_RED;
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        bus.loop_raw = 1'b0;
        bus.lr_light = LIGHT_RED;
        tick(2);
        check("reset_has_car", 32'(bus.lr_has_car), 32'd0);
        check("reset_queue", 32'(bus.queue_len), 32'd0);
        check("reset_fault", 32'(bus.sensor_fault), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Three-cycle glitch must be rejected by the debouncer.
        bus.loop_raw = 1'b1;
        tick(3);
        bus.loop_raw = 1'b0;
        tick(10);
        check("glitch_has_car", 32'(bus.lr_has_car), 32'd0);
        check("glitch_queue", 32'(bus.queue_len), 32'd0);
        check("glitch_fault", 32'(bus.sensor_fault), 32'd0);

        // Held loop: request appears exactly six edges after first sample.
        bus.loop_raw = 1'b1;
        tick(6);
        check("arrive_early", 32'(bus.lr_has_car), 32'd0);
        tick(1);
        check("arrive_has_car", 32'(bus.lr_has_car), 32'd1);
        check("arrive_queue", 32'(bus.queue_len), 32'd1);

        bus.lr_light = LIGHT_GREEN;
        tick(1);
        check("green_has_car", 32'(bus.lr_has_car), 32'd0);
        check("green_queue", 32'(bus.queue_len), 32'd0);
        bus.lr_light = LIGHT_YELLOW;
        tick(1);
        check("yellow_rerequest", 32'(bus.lr_has_car), 32'd1);
        check("yellow_queue", 32'(bus.queue_len), 32'd0);

        do_reset();
        pulses(3);
        check("three_cars_queue", 32'(bus.queue_len), 32'd3);
        check("three_cars_has_car", 32'(bus.lr_has_car), 32'd1);
        pulses(17);
        check("twenty_cars_sat", 32'(bus.queue_len), 32'd15);

        // Mid-operation reset while requesting with five queued cars.
        do_reset();
        pulses(5);
        check("pre_rst_queue", 32'(bus.queue_len), 32'd5);
        check("pre_rst_has_car", 32'(bus.lr_has_car), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_has_car", 32'(bus.lr_has_car), 32'd0);
        check("mid_rst_queue", 32'(bus.queue_len), 32'd0);
        check("mid_rst_fault", 32'(bus.sensor_fault), 32'd0);
        rst_n = 1'b1;
        tick(10);
        check("post_rst_idle", 32'(bus.lr_has_car), 32'd0);
        pulses(1);
        check("post_rst_rereq", 32'(bus.lr_has_car), 32'd1);
        check("post_rst_queue", 32'(bus.queue_len), 32'd1);

        // Stuck sensor: 200th debounced-high edge is the 206th edge after first sample.
        do_reset();
        bus.loop_raw = 1'b1;
        tick(205);
        check("stuck_pre_fault", 32'(bus.sensor_fault), 32'd0);
        check("stuck_pre_has_car", 32'(bus.lr_has_car), 32'd1);
        check("stuck_pre_queue", 32'(bus.queue_len), 32'd1);
        tick(1);
        check("stuck_fault", 32'(bus.sensor_fault), 32'd1);
        check("stuck_has_car", 32'(bus.lr_has_car), 32'd1);
        check("stuck_queue", 32'(bus.queue_len), 32'd0);
        tick(44);
        check("stuck_hold", 32'(bus.sensor_fault), 32'd1);
        bus.loop_raw = 1'b0;
        tick(6);
        check("release_still_fault", 32'(bus.sensor_fault), 32'd1);
        check("release_still_has_car", 32'(bus.lr_has_car), 32'd1);
        tick(1);
        check("release_fault", 32'(bus.sensor_fault), 32'd0);
        check("release_has_car", 32'(bus.lr_has_car), 32'd0);
        check("release_queue", 32'(bus.queue_len), 32'd0);
        check("release_state", 32'(dut.state), 32'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
